// File: rtl/synth_pkg.sv
// synth_pkg: scan-code constants, note table and shared types for the voice allocator.
package synth_pkg;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;
    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] KEY_OCT_UP = 8'h55;
    localparam logic [7:0] KEY_OCT_DN = 8'h4E;
    localparam logic [7:0] KEY_PANIC  = 8'h76;
    localparam int NUM_NOTES = 20;
    localparam logic [7:0] NOTE_CODE [NUM_NOTES] = '{
        8'h15, 8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35,
        8'h33, 8'h3B, 8'h43, 8'h42, 8'h44, 8'h4B, 8'h4D, 8'h4C, 8'h52, 8'h5B};
    localparam logic [10:0] NOTE_TONE [NUM_NOTES] = '{
        11'd400, 11'd423, 11'd448, 11'd475, 11'd503, 11'd533, 11'd565, 11'd599, 11'd634, 11'd672,
        11'd712, 11'd755, 11'd800, 11'd847, 11'd897, 11'd951, 11'd1007, 11'd1067, 11'd1131, 11'd1198};
    typedef logic signed [1:0] octave_t;
    localparam octave_t OCT_UP = 2'sb01;
    localparam octave_t OCT_DN = 2'sb11;
    localparam int TONE_SILENT = 1;
    typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} parse_state_t;
endpackage

// File: rtl/note_lut.sv
// note_lut: combinational scan code to base tone lookup.
module note_lut
    import synth_pkg::*;
#(
    parameter int TONE_W = 16
) (
    input  logic [7:0]        code,
    output logic              hit,
    output logic [TONE_W-1:0] base
);
    always_comb begin
        hit  = 1'b0;
        base = '0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (code == NOTE_CODE[i]) begin
                hit  = 1'b1;
                base = TONE_W'(NOTE_TONE[i]);
            end
        end
    end
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: parses PS/2 scan codes and assigns held notes to tone channels,
// stealing the oldest voice when every channel is sounding.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int TONE_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               scan_code,
    input  logic                     scan_valid,
    output logic [NUM_CH*TONE_W-1:0] tone,
    output logic [NUM_CH-1:0]        gate,
    output logic [1:0]               octave
);
    localparam int IW = $clog2(NUM_CH);

    parse_state_t state_q, state_d;
    logic do_make, do_break;
    logic [NUM_CH-1:0][7:0]        code_q, code_d;
    logic [NUM_CH-1:0]             gate_q, gate_d;
    logic [NUM_CH-1:0][TONE_W-1:0] tone_q, tone_d;
    logic [NUM_CH-1:0][IW-1:0]     age_q, age_d;
    octave_t                       octave_q, octave_d;
    logic              lut_hit, held, free_found;
    logic [TONE_W-1:0] base, shifted;
    logic [IW-1:0]     free_idx, victim_idx, match_idx, tgt;

    note_lut #(.TONE_W(TONE_W)) u_lut (.code(scan_code), .hit(lut_hit), .base(base));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = !scan_valid ? state_q :
                  state_q == ST_IDLE ? (scan_code == PREFIX_EXT ? ST_EXT :
                                        scan_code == PREFIX_BRK ? ST_BRK : ST_IDLE) :
                  (state_q == ST_EXT && scan_code == PREFIX_BRK) ? ST_EXT_BRK : ST_IDLE;
    end

    always_comb begin
        do_make  = scan_valid && state_q == ST_IDLE && scan_code != PREFIX_EXT && scan_code != PREFIX_BRK;
        do_break = scan_valid && state_q == ST_BRK;
    end

    // Channel search: lowest free slot, oldest active voice, and the voice already holding this code.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        held       = 1'b0;
        match_idx  = '0;
        victim_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (!gate_q[k]) begin
                free_found = 1'b1;
                free_idx   = IW'(k);
            end
            if (gate_q[k] && code_q[k] == scan_code) begin
                held      = 1'b1;
                match_idx = IW'(k);
            end
        end
        for (int k = 1; k < NUM_CH; k++)
            if (age_q[k] > age_q[victim_idx]) victim_idx = IW'(k);
        tgt     = free_found ? free_idx : victim_idx;
        shifted = octave_q == OCT_UP ? base << 1 : octave_q == OCT_DN ? base >> 1 : base;
    end

    always_comb begin
        code_d   = code_q;
        gate_d   = gate_q;
        tone_d   = tone_q;
        age_d    = age_q;
        octave_d = octave_q;
        if (do_make) begin
            if (scan_code == KEY_OCT_UP)
                octave_d = octave_q == OCT_UP ? octave_q : octave_q + 2'sd1;
            else if (scan_code == KEY_OCT_DN)
                octave_d = octave_q == OCT_DN ? octave_q : octave_q - 2'sd1;
            else if (scan_code == KEY_PANIC) begin
                gate_d = '0;
                code_d = '0;
                age_d  = '0;
            end else if (lut_hit && !held) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (IW'(k) == tgt) begin
                        code_d[k] = scan_code;
                        gate_d[k] = 1'b1;
                        tone_d[k] = shifted;
                        age_d[k]  = '0;
                    end else if (gate_q[k])
                        age_d[k] = age_q[k] + IW'(1);
                end
            end
        end else if (do_break && held) begin
            for (int k = 0; k < NUM_CH; k++)
                if (gate_q[k] && age_q[k] > age_q[match_idx]) age_d[k] = age_q[k] - IW'(1);
            gate_d[match_idx] = 1'b0;
            code_d[match_idx] = '0;
            age_d[match_idx]  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_q   <= '0;
            gate_q   <= '0;
            tone_q   <= {NUM_CH{TONE_W'(TONE_SILENT)}};
            age_q    <= '0;
            octave_q <= '0;
        end else begin
            code_q   <= code_d;
            gate_q   <= gate_d;
            tone_q   <= tone_d;
            age_q    <= age_d;
            octave_q <= octave_d;
        end
    end

    assign tone   = tone_q;
    assign gate   = gate_q;
    assign octave = octave_q;
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed table, corner sequences and random bytes against a recency-queue model.
module tb_voice_allocator;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  scan_code = 8'h00;
    logic        scan_valid = 1'b0;
    logic [63:0] tone;
    logic [3:0]  gate;
    logic [1:0]  octave;

    int checks = 0;
    int failures = 0;

    voice_allocator #(.NUM_CH(4), .TONE_W(16)) dut (
        .clk(clk), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
        .tone(tone), .gate(gate), .octave(octave)
    );

    always #5 clk = ~clk;

    // Reference model: channels plus a recency queue (front = newest note).
    int         note_tbl [256];
    logic [7:0] m_code [4];
    logic [3:0] m_gate;
    int         m_tone [4];
    int         m_oct;
    int         order [$];
    bit         m_brk, m_ext, m_ext_brk;

    task automatic m_reset();
        for (int k = 0; k < 4; k++) begin
            m_code[k] = 8'h00;
            m_tone[k] = 1;
        end
        m_gate = 4'b0000;
        m_oct = 0;
        order.delete();
        m_brk = 0;
        m_ext = 0;
        m_ext_brk = 0;
    endtask

    task automatic m_make(input logic [7:0] b);
        int ch = -1;
        if (b == 8'h55) begin
            if (m_oct < 1) m_oct++;
        end else if (b == 8'h4E) begin
            if (m_oct > -1) m_oct--;
        end else if (b == 8'h76) begin
            m_gate = 4'b0000;
            for (int k = 0; k < 4; k++) m_code[k] = 8'h00;
            order.delete();
        end else if (note_tbl[b] != 0) begin
            for (int k = 0; k < 4; k++)
                if (m_gate[k] && m_code[k] == b) return;
            for (int k = 3; k >= 0; k--)
                if (!m_gate[k]) ch = k;
            if (ch < 0) ch = order.pop_back();
            order.push_front(ch);
            m_code[ch] = b;
            m_gate[ch] = 1'b1;
            m_tone[ch] = m_oct == 1 ? note_tbl[b] * 2 : m_oct == -1 ? note_tbl[b] / 2 : note_tbl[b];
        end
    endtask

    task automatic m_break(input logic [7:0] b);
        for (int k = 0; k < 4; k++) begin
            if (m_gate[k] && m_code[k] == b) begin
                m_gate[k] = 1'b0;
                m_code[k] = 8'h00;
                for (int i = 0; i < order.size(); i++)
                    if (order[i] == k) begin
                        order.delete(i);
                        break;
                    end
                return;
            end
        end
    endtask

    task automatic m_apply(input logic [7:0] b);
        if (m_brk) begin
            m_brk = 0;
            m_break(b);
        end else if (m_ext_brk)
            m_ext_brk = 0;
        else if (m_ext) begin
            m_ext = 0;
            if (b == 8'hF0) m_ext_brk = 1;
        end else if (b == 8'hE0)
            m_ext = 1;
        else if (b == 8'hF0)
            m_brk = 1;
        else
            m_make(b);
    endtask

    task automatic check_model(input string tag);
        checks++;
        if (gate !== m_gate) begin
            failures++;
            $display("FAIL %s gate got=%b exp=%b", tag, gate, m_gate);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (tone[k*16 +: 16] !== 16'(m_tone[k])) begin
                failures++;
                $display("FAIL %s tone%0d got=%0d exp=%0d", tag, k, tone[k*16 +: 16], m_tone[k]);
            end
        end
        checks++;
        if (octave !== 2'(m_oct)) begin
            failures++;
            $display("FAIL %s octave got=%b exp=%b", tag, octave, 2'(m_oct));
        end
    endtask

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_code = b;
        scan_valid = 1'b1;
        m_apply(b);
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [7:0] code;
        logic [3:0] gate;
        int         ch;
        int         tone;
        logic [1:0] oct;
    } vec_t;
    vec_t tbl [25];

    logic [7:0] pool [16];

    initial begin
        foreach (note_tbl[i]) note_tbl[i] = 0;
        note_tbl[8'h15] = 400;  note_tbl[8'h1C] = 423;  note_tbl[8'h1D] = 448;  note_tbl[8'h1B] = 475;
        note_tbl[8'h24] = 503;  note_tbl[8'h23] = 533;  note_tbl[8'h2B] = 565;  note_tbl[8'h2C] = 599;
        note_tbl[8'h34] = 634;  note_tbl[8'h35] = 672;  note_tbl[8'h33] = 712;  note_tbl[8'h3B] = 755;
        note_tbl[8'h43] = 800;  note_tbl[8'h42] = 847;  note_tbl[8'h44] = 897;  note_tbl[8'h4B] = 951;
        note_tbl[8'h4D] = 1007; note_tbl[8'h4C] = 1067; note_tbl[8'h52] = 1131; note_tbl[8'h5B] = 1198;

        tbl[0]  = '{8'hF0, 4'b0000, 0, 1, 2'b00};
        tbl[1]  = '{8'h2B, 4'b0000, 0, 1, 2'b00};
        tbl[2]  = '{8'hE0, 4'b0000, 0, 1, 2'b00};
        tbl[3]  = '{8'hF0, 4'b0000, 0, 1, 2'b00};
        tbl[4]  = '{8'h1C, 4'b0000, 1, 1, 2'b00};
        tbl[5]  = '{8'h2B, 4'b0001, 0, 565, 2'b00};
        tbl[6]  = '{8'h34, 4'b0011, 1, 634, 2'b00};
        tbl[7]  = '{8'h33, 4'b0111, 2, 712, 2'b00};
        tbl[8]  = '{8'h2B, 4'b0111, 0, 565, 2'b00};
        tbl[9]  = '{8'h3B, 4'b1111, 3, 755, 2'b00};
        tbl[10] = '{8'h42, 4'b1111, 0, 847, 2'b00};
        tbl[11] = '{8'hF0, 4'b1111, 0, 847, 2'b00};
        tbl[12] = '{8'h2B, 4'b1111, 0, 847, 2'b00};
        tbl[13] = '{8'hF0, 4'b1111, 1, 634, 2'b00};
        tbl[14] = '{8'h34, 4'b1101, 1, 634, 2'b00};
        tbl[15] = '{8'h4B, 4'b1111, 1, 951, 2'b00};
        tbl[16] = '{8'h55, 4'b1111, 1, 951, 2'b01};
        tbl[17] = '{8'h55, 4'b1111, 1, 951, 2'b01};
        tbl[18] = '{8'h2B, 4'b1111, 2, 1130, 2'b01};
        tbl[19] = '{8'h4E, 4'b1111, 2, 1130, 2'b00};
        tbl[20] = '{8'h4E, 4'b1111, 2, 1130, 2'b11};
        tbl[21] = '{8'h4E, 4'b1111, 2, 1130, 2'b11};
        tbl[22] = '{8'h34, 4'b1111, 3, 317, 2'b11};
        tbl[23] = '{8'h56, 4'b1111, 2, 1130, 2'b11};
        tbl[24] = '{8'h76, 4'b0000, 3, 317, 2'b11};

        m_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("reset_gate", int'(gate), 0);
        check_val("reset_tone2", int'(tone[32 +: 16]), 1);
        check_val("reset_octave", int'(octave), 0);
        check_model("reset");

        foreach (tbl[i]) begin
            send(tbl[i].code);
            check_val($sformatf("tbl%0d_gate", i), int'(gate), int'(tbl[i].gate));
            check_val($sformatf("tbl%0d_tone%0d", i, tbl[i].ch), int'(tone[tbl[i].ch*16 +: 16]), tbl[i].tone);
            check_val($sformatf("tbl%0d_octave", i), int'(octave), int'(tbl[i].oct));
            check_model($sformatf("tbl%0d", i));
        end

        // Release mid-stack, reuse of the freed slot, then a steal that depends on the decremented ages.
        do_reset();
        send(8'h2B); send(8'h34); send(8'h33);
        send(8'hF0); send(8'h34);
        check_val("rel_gate", int'(gate), 4'b0101);
        check_val("rel_tone1_hold", int'(tone[16 +: 16]), 634);
        send(8'h4B);
        check_val("reuse_gate", int'(gate), 4'b0111);
        check_val("reuse_tone1", int'(tone[16 +: 16]), 951);
        send(8'h1C); send(8'h23);
        check_val("age_steal_tone0", int'(tone[0 +: 16]), 533);
        check_val("age_steal_tone2", int'(tone[32 +: 16]), 712);
        check_model("age_seq");

        // Reset while a break prefix is pending.
        send(8'h76);
        send(8'h2B); send(8'h34); send(8'h33); send(8'h3B);
        check_val("full_gate", int'(gate), 4'b1111);
        send(8'hF0);
        @(negedge clk);
        reset = 1'b1;
        m_reset();
        #1;
        check_val("midbrk_gate", int'(gate), 0);
        check_val("midbrk_tone0", int'(tone[0 +: 16]), 1);
        check_val("midbrk_tone3", int'(tone[48 +: 16]), 1);
        @(negedge clk);
        reset = 1'b0;
        send(8'h2B);
        check_val("after_reset_make", int'(gate), 4'b0001);
        check_model("after_reset");

        // Randomized byte stream with back-to-back strobes and idle gaps.
        pool = '{8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h15, 8'h5B, 8'h4B,
                 8'hF0, 8'hF0, 8'hF0, 8'hE0, 8'h55, 8'h4E, 8'h76, 8'h00};
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] b;
            int sel;
            @(negedge clk);
            check_model("rand");
            sel = $urandom_range(0, 99);
            b = sel < 45 ? pool[$urandom_range(0, 7)] :
                sel < 75 ? 8'hF0 :
                sel < 80 ? 8'hE0 :
                sel < 86 ? pool[$urandom_range(12, 13)] :
                sel < 88 ? 8'h76 : 8'($urandom);
            scan_valid = $urandom_range(0, 3) != 0;
            scan_code = b;
            if (scan_valid) m_apply(b);
        end
        @(negedge clk);
        scan_valid = 1'b0;
        check_model("rand_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
